// File: rtl/hack_ram_if.sv
// Bus bundle for hack_ram: write/read port A, read-only port B and the busy flag.
// The master drives addresses and write data; the slave (the RAM) returns read data.
interface hack_ram_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);

  logic [WIDTH-1:0]  in;
  logic              load;
  logic [ADDR_W-1:0] address;
  logic [ADDR_W-1:0] address_b;
  logic [WIDTH-1:0]  out;
  logic [WIDTH-1:0]  out_b;
  logic              busy;

  modport master (
    output in, load, address, address_b,
    input  out, out_b, busy
  );

  modport slave (
    input  in, load, address, address_b,
    output out, out_b, busy
  );

endinterface

// File: rtl/hack_ram.sv
// Hack-platform word RAM (RAM8..RAM16K) with a post-reset clear sequencer
// and a second combinational read port for debug/screen access.
module hack_ram #(
  parameter int WIDTH          = 16,
  parameter int ADDR_W         = 3,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  hack_ram_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_ptr_next;
  logic              clearing;

  logic [WIDTH-1:0]  mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end

  // The clear pointer only advances in CLEAR; its wrap coincides with leaving CLEAR.
  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    clearing     = 1'b0;
    case (state)
      CLEAR: begin
        clearing     = 1'b1;
        clr_ptr_next = clr_ptr + 1'b1;
        if (clr_ptr == {ADDR_W{1'b1}}) begin
          state_next = READY;
        end
      end
      READY: begin
        state_next = READY;
      end
      default: begin
        state_next = READY;
      end
    endcase
  end

  // The array has no reset; the sequencer zeroes it one word per cycle instead.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clr_ptr] <= '0;
    end else if (bus.load) begin
      mem[bus.address] <= bus.in;
    end
  end

  assign bus.busy  = clearing;
  assign bus.out   = clearing ? '0 : mem[bus.address];
  assign bus.out_b = clearing ? '0 : mem[bus.address_b];

endmodule

// File: tb/tb_hack_ram.sv
// Scoreboard bench for hack_ram: a RAM8 with clear-on-reset and a RAM64 without it.
// Stimulus queues expected values; a monitor compares them when the bench strobes a sample.
module tb_hack_ram;

  logic clk;
  logic rst_n;

  hack_ram_if #(.WIDTH(16), .ADDR_W(3)) bus_a ();
  hack_ram_if #(.WIDTH(16), .ADDR_W(6)) bus_b ();

  hack_ram #(.WIDTH(16), .ADDR_W(3), .CLEAR_ON_RESET(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  hack_ram #(.WIDTH(16), .ADDR_W(6), .CLEAR_ON_RESET(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    string       name;
    int          port;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   num_checks = 0;
  int   num_fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] observe(input int port);
    case (port)
      0:       observe = bus_a.out;
      1:       observe = bus_a.out_b;
      2:       observe = {15'b0, bus_a.busy};
      3:       observe = bus_b.out;
      default: observe = {15'b0, bus_b.busy};
    endcase
  endfunction

  // Monitor: drains every queued expectation whenever the bench presents a sample point.
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(sample_ev);
      #1;
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = observe(e.port);
        num_checks++;
        if (act !== e.exp) begin
          num_fails++;
          $display("[TB] FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] din, input logic ld,
                               input logic [2:0] a, input logic [2:0] ab);
    bus_a.in        = din;
    bus_a.load      = ld;
    bus_a.address   = a;
    bus_a.address_b = ab;
  endtask

  task automatic checkOutput(input string name, input int port, input logic [15:0] exp);
    exp_t e;
    e.name = name;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic present();
    -> sample_ev;
    #2;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus_b.in        = '0;
    bus_b.load      = 1'b0;
    bus_b.address   = '0;
    bus_b.address_b = '0;
    applyStimulus(16'h0000, 1'b0, 3'd0, 3'd0);

    // Reset held for three cycles: RAM8 busy with outputs forced low, RAM64 idle.
    repeat (3) begin
      next_cycle();
      checkOutput("rst_busy", 2, 16'h0001);
      checkOutput("rst_out", 0, 16'h0000);
      present();
    end
    rst_n = 1'b1;
    checkOutput("b_busy_after_rst", 4, 16'h0000);

    // Clear sequence with a write attempt that must be dropped.
    applyStimulus(16'hBEEF, 1'b1, 3'd3, 3'd3);
    for (int k = 0; k < 8; k++) begin
      checkOutput("clear_busy", 2, 16'h0001);
      checkOutput("clear_out", 0, 16'h0000);
      checkOutput("clear_out_b", 1, 16'h0000);
      present();
      next_cycle();
    end
    applyStimulus(16'h0000, 1'b0, 3'd0, 3'd0);
    checkOutput("busy_fall", 2, 16'h0000);
    present();

    for (int a = 0; a < 8; a++) begin
      applyStimulus(16'h0000, 1'b0, 3'(a), 3'(7 - a));
      checkOutput("zero_a", 0, 16'h0000);
      checkOutput("zero_b", 1, 16'h0000);
      present();
    end

    // Write ordering: old value before the edge, new value after, load=0 holds.
    applyStimulus(16'h1234, 1'b1, 3'd5, 3'd5);
    checkOutput("pre_write_out", 0, 16'h0000);
    checkOutput("pre_write_out_b", 1, 16'h0000);
    present();
    next_cycle();
    applyStimulus(16'hFFFF, 1'b0, 3'd5, 3'd5);
    checkOutput("post_write_out", 0, 16'h1234);
    checkOutput("post_write_out_b", 1, 16'h1234);
    present();
    next_cycle();
    checkOutput("hold_out", 0, 16'h1234);
    present();

    // Dual port reads and combinational swap.
    applyStimulus(16'hA5A5, 1'b1, 3'd2, 3'd0);
    next_cycle();
    applyStimulus(16'h5A5A, 1'b1, 3'd7, 3'd0);
    next_cycle();
    applyStimulus(16'h0000, 1'b0, 3'd2, 3'd7);
    checkOutput("dual_out", 0, 16'hA5A5);
    checkOutput("dual_out_b", 1, 16'h5A5A);
    present();
    applyStimulus(16'h0000, 1'b0, 3'd7, 3'd2);
    checkOutput("swap_out", 0, 16'h5A5A);
    checkOutput("swap_out_b", 1, 16'hA5A5);
    present();

    // Full re-clear, interrupted after four edges and restarted from zero.
    applyStimulus(16'h0000, 1'b0, 3'd5, 3'd2);
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checkOutput("partial_busy", 2, 16'h0001);
      present();
      next_cycle();
    end
    rst_n = 1'b0;
    checkOutput("midreset_busy", 2, 16'h0001);
    checkOutput("midreset_out", 0, 16'h0000);
    present();
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checkOutput("reclear_busy", 2, 16'h0001);
      present();
      next_cycle();
    end
    checkOutput("reclear_busy_fall", 2, 16'h0000);
    present();
    for (int a = 0; a < 8; a++) begin
      applyStimulus(16'h0000, 1'b0, 3'(a), 3'(a));
      checkOutput("rezero_a", 0, 16'h0000);
      checkOutput("rezero_b", 1, 16'h0000);
      present();
    end

    // RAM64 without clear: fill every word, then read each back.
    checkOutput("b_busy_ready", 4, 16'h0000);
    present();
    for (int i = 0; i < 64; i++) begin
      bus_b.address = 6'(i);
      bus_b.in      = 16'h0040 + 16'(i);
      bus_b.load    = 1'b1;
      next_cycle();
    end
    bus_b.load = 1'b0;
    bus_b.in   = 16'hFFFF;
    for (int i = 0; i < 64; i++) begin
      bus_b.address = 6'(i);
      checkOutput("ram64_read", 3, 16'h0040 + 16'(i));
      present();
    end

    #5;
    if (sb.size() != 0) begin
      num_fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/hack_ram.md
Name: hack_ram

Overview:
- Parametrised word-addressable memory for the Hack platform; generalises the single-bit load register to an array of WIDTH-bit registers with 2**ADDR_W entries.
- Default configuration is RAM8. ADDR_W=6, 9, 12 or 14 yields RAM64 through RAM16K.
- Adds a hardware clear sequencer after reset and a second asynchronous read port for debug/screen access.
- Sits under the CPU data-memory map and is used by the memory and computer top levels.

Parameters:
- WIDTH, 16: data word width in bits.
- ADDR_W, 3: address width; DEPTH = 2**ADDR_W.
- CLEAR_ON_RESET, 1: 1 = zero every word after reset; 0 = skip the clear, contents undefined after reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in  in  WIDTH  write data.
- load  in  1  write enable; in is stored at address on the rising edge.
- address  in  ADDR_W  port A address, used for both write and read.
- out  out  WIDTH  port A read data: mem[address].
- address_b  in  ADDR_W  port B read-only address.
- out_b  out  WIDTH  port B read data: mem[address_b].
- busy  out  1  high while the clear sequence runs; writes are ignored while high.

Behaviour:
- Storage: DEPTH x WIDTH register array. The array itself is not asynchronously reset.
- Read: combinational. out = mem[address] and out_b = mem[address_b], settling within the same cycle as an address change.
- Write timing: a write with load=1 at edge N is visible on out/out_b only after edge N. Before the edge, out shows the old value (no write-through), matching Bit/Register semantics.
- Reads and writes in the same cycle on the same address: the read returns the old data; the new data appears after the edge.
- Port B never writes. If address_b == address and a write occurs, out_b updates after the edge, identically to out.
- FSM states: CLEAR, READY. There is a clear pointer clr_ptr, ADDR_W bits wide.
- On rst_n low (asynchronous):
  - If CLEAR_ON_RESET=1: state=CLEAR, clr_ptr=0, busy=1.
  - If CLEAR_ON_RESET=0: state=READY, busy=0.
  - These hold for as long as rst_n stays low.
- CLEAR state, on each rising edge with rst_n high:
  - mem[clr_ptr] <= 0 and clr_ptr <= clr_ptr+1.
  - On the edge that clears clr_ptr == DEPTH-1, go to READY; busy falls after that edge.
  - busy is therefore high for exactly DEPTH rising edges after reset release.
- While busy=1:
  - load is ignored; no user write occurs regardless of in/address.
  - out and out_b are forced to 0.
- READY state: normal operation; stays in READY until rst_n is asserted again.
- Reset asserted mid-clear: the sequence restarts from clr_ptr=0.
- Reset asserted during READY: with CLEAR_ON_RESET=1, contents are re-zeroed by a full new clear.
- Wrap-around: clr_ptr wraps DEPTH-1 to 0 only at the CLEAR-to-READY transition and is unused afterwards.
- Address widths are exact, so there are no out-of-range addresses.
- CLEAR_ON_RESET=0: contents are X until written. The bench must only read written locations.

Test Plan:
- Reset sequence, defaults (WIDTH=16, ADDR_W=3): hold rst_n=0 for 3 cycles, release -> busy=1 for exactly 8 rising edges, then 0; out=0 throughout; afterwards every address reads 16'h0000 on both ports.
- Write ignored while busy: load=1, address=3, in=16'hBEEF applied during the clear -> after busy falls, mem[3] reads 16'h0000.
- Write/read ordering: in READY, address=5, in=16'h1234, load=1 -> out stays at the old value 16'h0000 before the edge and reads 16'h1234 after the edge. Then load=0, in=16'hFFFF -> out stays 16'h1234.
- Dual port: write 16'hA5A5 to address 2 and 16'h5A5A to address 7; set address=2, address_b=7 -> out=16'hA5A5, out_b=16'h5A5A. Swap addresses -> the values swap combinationally, with no clock needed.
- Reset mid-clear: assert rst_n=0 after 4 clear edges, release -> busy stays high for a full 8 further edges; all words read 0.
- Scaled configuration (ADDR_W=6, CLEAR_ON_RESET=0): busy=0 immediately after reset. Write 16'h0040+i to each address i=0..63, read all back -> exact match, 0 errors.
